// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Controller FSM states; the debug port exposes this encoding directly.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_PEND  = 2'd2
  } state_t;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_pkg

// File: rtl/hazard_cmp.sv
// Load-use dependency comparator between the load in ID/EX and the
// source registers of the instruction in ID. Purely combinational.
module hazard_cmp
  import hazard_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  // rt only matters when the ID instruction actually reads it.
  assign rt_match = id_uses_rt && (ex_rt == id_rt);

  // A load into $zero produces no value anyone can depend on.
  assign hazard = ex_memread && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule : hazard_cmp

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and
// whole-pipeline freeze while data memory is busy. A branch resolved while
// memory is busy is remembered in BR_PEND and its flush is applied once the
// pipeline unfreezes. Also counts PC-stall cycles with a saturating counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             load_use;

  hazard_cmp u_cmp (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .hazard     (load_use)
  );

  // State register; reset also drops any pending branch (held as BR_PEND).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and control outputs from the current state and live inputs.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    state_next  = RUN;

    if (mem_busy) begin
      // Freeze everything; keep (or start) remembering a taken branch.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
      if (ex_branch_taken || (state_reg == BR_PEND)) begin
        state_next = BR_PEND;
      end else begin
        state_next = MEM_WAIT;
      end
    end else begin
      case (state_reg)
        BR_PEND: begin
          // Apply the deferred branch flush; the live branch input is stale.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        default: begin
          // RUN, MEM_WAIT after memory completes, and the unused encoding
          // all behave as a normal running cycle.
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  // Count cycles where the PC is held, sticking at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (!pc_write && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  assign state     = state_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with hand-computed expectations.
// A second instance with a 4-bit counter exercises saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, ex_branch_taken, mem_busy;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  logic        pc_write4, ifid_write4, ifid_flush4, idex_flush4, pipe_freeze4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_freeze(pipe_freeze), .state(state),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
    .idex_flush(idex_flush4), .pipe_freeze(pipe_freeze4), .state(state4),
    .stall_cnt(stall_cnt4)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic mrd,
                        input logic [4:0] xrt, input logic br,
                        input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_memread = mrd;
    ex_rt = xrt; ex_branch_taken = br; mem_busy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string name);
    $display("vec %-12s pc_w=%0b ifid_w=%0b ifid_fl=%0b idex_fl=%0b frz=%0b st=%0d cnt=%0d",
             name, pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze,
             state, stall_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #3;
    show("reset");
    check_val("rst_state", state, 0);
    check_val("rst_cnt", stall_cnt, 0);
    check_val("rst_pc_write", pc_write, 1);
    check_val("rst_freeze", pipe_freeze, 0);
    tick();
    rst_n = 1'b1;

    // Load-use on rs: one bubble cycle.
    set_in(8, 0, 0, 1, 8, 0, 0);
    #2; show("lu_rs");
    check_val("lu_rs_pc_write", pc_write, 0);
    check_val("lu_rs_ifid_write", ifid_write, 0);
    check_val("lu_rs_idex_flush", idex_flush, 1);
    check_val("lu_rs_ifid_flush", ifid_flush, 0);
    check_val("lu_rs_freeze", pipe_freeze, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2; show("after_lu");
    check_val("lu_rs_cnt", stall_cnt, 1);
    check_val("lu_rs_state", state, 0);
    check_val("after_lu_pc_write", pc_write, 1);
    check_val("after_lu_idex_flush", idex_flush, 0);
    tick();

    // rt match but rt not used: no hazard.
    set_in(1, 7, 0, 1, 7, 0, 0);
    #2; show("rt_unused");
    check_val("rt_unused_pc_write", pc_write, 1);
    tick();
    // rt match and rt used: hazard.
    set_in(1, 7, 1, 1, 7, 0, 0);
    #2; show("rt_used");
    check_val("rt_used_pc_write", pc_write, 0);
    check_val("rt_used_idex_flush", idex_flush, 1);
    tick();
    check_val("rt_used_cnt", stall_cnt, 2);

    // Load into $zero never stalls.
    set_in(0, 0, 1, 1, 0, 0, 0);
    #2; show("zero_reg");
    check_val("zero_pc_write", pc_write, 1);
    check_val("zero_idex_flush", idex_flush, 0);
    tick();

    // Not a load: matching registers do not stall.
    set_in(8, 0, 0, 0, 8, 0, 0);
    #2; show("no_load");
    check_val("noload_pc_write", pc_write, 1);
    tick();

    // Branch overrides simultaneous hazard.
    set_in(3, 5, 1, 1, 5, 1, 0);
    #2; show("br_hazard");
    check_val("br_ifid_flush", ifid_flush, 1);
    check_val("br_idex_flush", idex_flush, 1);
    check_val("br_pc_write", pc_write, 1);
    tick();
    check_val("br_state", state, 0);
    check_val("br_cnt", stall_cnt, 2);

    // Memory busy for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1);
      #2; show("mem_busy");
      check_val("mb_freeze", pipe_freeze, 1);
      check_val("mb_pc_write", pc_write, 0);
      check_val("mb_ifid_write", ifid_write, 0);
      check_val("mb_flush", {ifid_flush, idex_flush}, 0);
      tick();
      check_val("mb_state", state, 1);
    end
    check_val("mb_cnt", stall_cnt, 5);
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2; show("mem_done");
    check_val("md_pc_write", pc_write, 1);
    check_val("md_freeze", pipe_freeze, 0);
    tick();
    check_val("md_state", state, 0);
    check_val("md_cnt", stall_cnt, 5);

    // Memory busy with taken branch: branch remembered, flushed afterwards.
    set_in(0, 0, 0, 0, 0, 1, 1);
    #2; show("busy_br");
    check_val("bb_freeze", pipe_freeze, 1);
    check_val("bb_ifid_flush", ifid_flush, 0);
    tick();
    check_val("bb_state1", state, 2);
    set_in(0, 0, 0, 0, 0, 0, 1);
    #2; show("busy_pend");
    check_val("bp_freeze", pipe_freeze, 1);
    check_val("bp_idex_flush", idex_flush, 0);
    tick();
    check_val("bp_state", state, 2);
    check_val("bp_cnt", stall_cnt, 7);
    set_in(8, 0, 0, 1, 8, 1, 0);
    #2; show("pend_flush");
    check_val("pf_ifid_flush", ifid_flush, 1);
    check_val("pf_idex_flush", idex_flush, 1);
    check_val("pf_pc_write", pc_write, 1);
    check_val("pf_freeze", pipe_freeze, 0);
    tick();
    check_val("pf_state", state, 0);
    check_val("pf_cnt", stall_cnt, 7);
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2; show("idle");
    check_val("idle_ifid_flush", ifid_flush, 0);

    // Fresh reset, then 20 frozen cycles for saturation.
    rst_n = 1'b0;
    #1;
    check_val("rst2_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    show("sat");
    check_val("sat_cnt4", stall_cnt4, 15);
    check_val("sat_cnt16", stall_cnt, 20);
    check_val("sat_state", state, 1);

    // Asynchronous reset in the middle of MEM_WAIT.
    #2;
    rst_n = 1'b0;
    #1; show("async_rst");
    check_val("ar_state", state, 0);
    check_val("ar_cnt", stall_cnt, 0);
    check_val("ar_cnt4", stall_cnt4, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    #1; show("resume");
    check_val("res_state", state, 0);
    check_val("res_cnt", stall_cnt, 0);
    check_val("res_pc_write", pc_write, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_hazard_ctrl
